fir_coeff_ctrl: RTL and testbench

Configuration controller for the 3-parallel unfolded FIR (myfir, NB=14, 9 taps). It collects coefficient writes into a shadow bank and applies them to the filter's B0..B8 inputs only after the filter pipeline has drained. During the drain it gates the filter's valid input and back-pressures the upstream sample source, so no output sample ever mixes old and new coefficients. It sits between the data source/host and myfir, next to the VIN/B0..B8 connections.

---
 rtl/fir_coeff_ctrl.sv | 104 ++++++++++
 tb/tb_fir_coeff_ctrl.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/fir_coeff_ctrl.sv
// Coefficient controller for the 3-parallel unfolded FIR: double-buffered taps,
// swapped into the filter only once its pipeline has drained.
module fir_coeff_ctrl #(
  parameter int NB        = 14,
  parameter int NTAPS     = 9,
  parameter int DRAIN_CYC = 4
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                WE,
  input  logic [3:0]          WADDR,
  input  logic [NB-1:0]       WDATA,
  input  logic                COMMIT,
  input  logic                VIN_UP,
  output logic                VIN_FIR,
  input  logic                VOUT_FIR,
  output logic                STALL,
  output logic [NTAPS*NB-1:0] B_FLAT,
  output logic                BUSY,
  output logic                DONE,
  output logic                ERR
);

  localparam int            CW       = $clog2(DRAIN_CYC + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(DRAIN_CYC);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [3:0]    NTAPS_A  = 4'(NTAPS);

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    SWAP
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [NB-1:0] shadow [NTAPS];
  logic [NB-1:0] active [NTAPS];
  logic          done_q;
  logic          err_q;
  logic          addr_ok;

  assign addr_ok = (WADDR < NTAPS_A);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= RUN;
      cnt    <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      // NOTE: both banks are deliberately cleared; a commit right after reset must load zeros.
      for (int k = 0; k < NTAPS; k++) begin
        shadow[k] <= '0;
        active[k] <= '0;
      end
    end else begin
      done_q <= (state == SWAP);
      err_q  <= WE && !addr_ok;

      if (WE && addr_ok) begin
        shadow[WADDR] <= WDATA;
      end

      case (state)
        RUN: begin
          if (COMMIT) begin
            state <= DRAIN;
            cnt   <= CNT_LOAD;
          end
        end
        DRAIN: begin
          // Any filter output restarts the quiet-cycle count.
          if (VOUT_FIR) begin
            cnt <= CNT_LOAD;
          end else if (cnt == CNT_ONE) begin
            state <= SWAP;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        SWAP: begin
          // NOTE: non-blocking reads give the pre-edge shadow, so a write landing
          // in this same cycle is held back for the next commit.
          for (int k = 0; k < NTAPS; k++) begin
            active[k] <= shadow[k];
          end
          state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

  assign VIN_FIR = VIN_UP && (state == RUN);
  assign STALL   = (state != RUN);
  assign BUSY    = (state != RUN);
  assign DONE    = done_q;
  assign ERR     = err_q;

  for (genvar k = 0; k < NTAPS; k++) begin : g_bflat
    assign B_FLAT[k*NB +: NB] = active[k];
  end

endmodule

// File: tb/tb_fir_coeff_ctrl.sv
// Directed bench for fir_coeff_ctrl: reset, bank load, drain extension,
// boundary writes, ignored commits and reset during drain.
module tb_fir_coeff_ctrl;

  localparam int NB    = 14;
  localparam int NTAPS = 9;
  localparam int W     = NTAPS * NB;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          WE = 1'b0;
  logic [3:0]    WADDR = '0;
  logic [NB-1:0] WDATA = '0;
  logic          COMMIT = 1'b0;
  logic          VIN_UP = 1'b0;
  logic          VOUT_FIR = 1'b0;
  logic          VIN_FIR;
  logic          STALL;
  logic [W-1:0]  B_FLAT;
  logic          BUSY;
  logic          DONE;
  logic          ERR;

  int checks = 0;
  int errors = 0;

  fir_coeff_ctrl #(.NB(NB), .NTAPS(NTAPS), .DRAIN_CYC(4)) dut (
    .CLK(CLK), .RST(RST), .WE(WE), .WADDR(WADDR), .WDATA(WDATA),
    .COMMIT(COMMIT), .VIN_UP(VIN_UP), .VIN_FIR(VIN_FIR), .VOUT_FIR(VOUT_FIR),
    .STALL(STALL), .B_FLAT(B_FLAT), .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one cycle, then drive this cycle's inputs and let outputs settle.
  task automatic step(input logic we, input logic [3:0] a, input logic [NB-1:0] d,
                      input logic commit, input logic vin, input logic vout);
    @(posedge CLK);
    #1;
    WE = we; WADDR = a; WDATA = d; COMMIT = commit; VIN_UP = vin; VOUT_FIR = vout;
    #1;
  endtask

  task automatic idle();
    step(1'b0, 4'd0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  function automatic logic [W-1:0] put(input logic [W-1:0] f, input int k, input logic [NB-1:0] v);
    logic [W-1:0] r;
    r = f;
    r[k*NB +: NB] = v;
    return r;
  endfunction

  // One commit with VIN_UP held high. Optional extras: VOUT_FIR pulses on drain
  // cycles 1 and 3, commit re-asserted in DRAIN/SWAP, a write to B8 in SWAP,
  // a write to B2 in drain cycle 2, a write to B5 in the commit cycle.
  task automatic commit_seq(input string tag, input logic [W-1:0] old_b, input logic [W-1:0] new_b,
                            input bit ext, input bit recommit, input bit swap_wr,
                            input bit drain_wr, input bit commit_wr);
    int n;
    step(commit_wr, 4'd5, 14'h0555, 1'b1, 1'b1, 1'b0);
    check({tag, "_commit_vin"}, VIN_FIR, 1'b1);
    check({tag, "_commit_stall"}, STALL, 1'b0);
    n = ext ? 7 : 4;
    for (int r = 1; r <= n; r++) begin
      step(drain_wr && (r == 2), 4'd2, 14'h0ABC, recommit, 1'b1, ext && (r == 1 || r == 3));
      check($sformatf("%s_drain%0d_vin", tag, r), VIN_FIR, 1'b0);
      check($sformatf("%s_drain%0d_stall", tag, r), STALL, 1'b1);
      check($sformatf("%s_drain%0d_bflat", tag, r), B_FLAT, old_b);
    end
    step(swap_wr, 4'd8, 14'h2000, recommit, 1'b1, 1'b0);
    check({tag, "_swap_busy"}, BUSY, 1'b1);
    check({tag, "_swap_bflat"}, B_FLAT, old_b);
    check({tag, "_swap_done"}, DONE, 1'b0);
    step(1'b0, 4'd0, '0, 1'b0, 1'b1, 1'b0);
    check({tag, "_run_done"}, DONE, 1'b1);
    check({tag, "_run_bflat"}, B_FLAT, new_b);
    check({tag, "_run_stall"}, STALL, 1'b0);
    check({tag, "_run_vin"}, VIN_FIR, 1'b1);
    idle();
    check({tag, "_post_done"}, DONE, 1'b0);
    check({tag, "_post_stall"}, STALL, 1'b0);
  endtask

  logic [W-1:0] zero_b, load_b, bank2, bank3, bank4;

  initial begin
    zero_b = '0;
    load_b = '0;
    for (int k = 0; k < NTAPS; k++) load_b = put(load_b, k, 14'(16 * (k + 1)));
    bank2 = put(put(load_b, 4, 14'h1234), 5, 14'h0555);
    bank3 = put(bank2, 2, 14'h0ABC);
    bank4 = put(bank3, 8, 14'h2000);

    // Reset with shadow writes already taken and one pending at the reset edge.
    idle();
    idle();
    RST = 1'b0;
    step(1'b1, 4'd0, 14'h0123, 1'b0, 1'b0, 1'b0);
    step(1'b1, 4'd3, 14'h0055, 1'b0, 1'b0, 1'b0);
    RST = 1'b1;
    idle();
    idle();
    RST = 1'b0;
    check("rst_bflat", B_FLAT, zero_b);
    check("rst_busy", BUSY, 1'b0);
    check("rst_stall", STALL, 1'b0);
    check("rst_done", DONE, 1'b0);
    check("rst_err", ERR, 1'b0);
    commit_seq("empty", zero_b, zero_b, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Basic load of Bk = 16*(k+1).
    for (int k = 0; k < NTAPS; k++) step(1'b1, 4'(k), 14'(16 * (k + 1)), 1'b0, 1'b0, 1'b0);
    commit_seq("load", zero_b, load_b, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Drain extended by VOUT_FIR pulses; a write in the commit cycle is included.
    step(1'b1, 4'd4, 14'h1234, 1'b0, 1'b0, 1'b0);
    commit_seq("ext", load_b, bank2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

    // Out-of-range write: one-cycle ERR, shadow untouched.
    step(1'b1, 4'd9, 14'h3FFF, 1'b0, 1'b0, 1'b0);
    check("oor_err_same", ERR, 1'b0);
    idle();
    check("oor_err_next", ERR, 1'b1);
    idle();
    check("oor_err_clear", ERR, 1'b0);

    // Re-asserted commits ignored; drain write applied, SWAP-cycle write deferred.
    commit_seq("ign", bank2, bank3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    commit_seq("defer", bank3, bank4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset in the third drain cycle.
    step(1'b0, 4'd0, '0, 1'b1, 1'b1, 1'b0);
    idle();
    idle();
    idle();
    check("mid_stall_before", STALL, 1'b1);
    RST = 1'b1;
    idle();
    RST = 1'b0;
    check("mid_stall", STALL, 1'b0);
    check("mid_busy", BUSY, 1'b0);
    check("mid_bflat", B_FLAT, zero_b);
    check("mid_done", DONE, 1'b0);
    for (int i = 0; i < 6; i++) begin
      idle();
      check($sformatf("mid_after%0d_done", i), DONE, 1'b0);
      check($sformatf("mid_after%0d_stall", i), STALL, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
